// File: rtl/issue_queue_if.sv
// ============================================================================
// Module   : issue_queue_if
// Purpose  : Decode/issue handshake bundle for issue_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface issue_queue_if #(
  parameter int DEPTH = 4
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             flush_in;
  logic             push_valid_in;
  logic             push_ready_out;
  logic [2:0]       exec_unit_sel_in;
  logic [3:0]       exec_uop_in;
  logic             int_busy_in;
  logic             vec_busy_in;
  logic             lsu_busy_in;
  logic [2:0]       exec_unit_sel_out;
  logic [3:0]       exec_uop_out;
  logic [PTR_W:0]   count_out;
  logic [7:0]       drop_count_out;

  modport master (
    output flush_in, push_valid_in, exec_unit_sel_in, exec_uop_in,
           int_busy_in, vec_busy_in, lsu_busy_in,
    input  push_ready_out, exec_unit_sel_out, exec_uop_out,
           count_out, drop_count_out
  );

  modport slave (
    input  flush_in, push_valid_in, exec_unit_sel_in, exec_uop_in,
           int_busy_in, vec_busy_in, lsu_busy_in,
    output push_ready_out, exec_unit_sel_out, exec_uop_out,
           count_out, drop_count_out
  );
endinterface

`default_nettype wire

// File: rtl/issue_queue.sv
// ============================================================================
// Module   : issue_queue
// Purpose  : In-order dispatch queue; head issues only when its unit is free.
//            Optional zero-latency empty-queue bypass: ISSUE_QUEUE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clock_in,
  input  logic          reset_in,
  issue_queue_if.slave  bus
);
  localparam int                PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0]    c_depth   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0]  c_ptr_one = PTR_W'(1);

  logic [2:0]       r_sel_mem [DEPTH];
  logic [3:0]       r_uop_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [7:0]       r_drop_cnt;

  logic             w_empty;
  logic             w_full;
  logic [2:0]       w_head_sel;
  logic [3:0]       w_head_uop;
  logic             w_issue;
  logic             w_drop_head;
  logic             w_drop_in;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_write;
  logic             w_drop_any;

  function automatic logic is_legal(input logic [2:0] sel);
    return (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
  endfunction

  function automatic logic unit_busy(input logic [2:0] sel, input logic ib,
                                     input logic vb, input logic lb);
    return (sel[0] & ib) | (sel[1] & vb) | (sel[2] & lb);
  endfunction

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_depth);
  assign w_head_sel  = r_sel_mem[r_rd_ptr];
  assign w_head_uop  = r_uop_mem[r_rd_ptr];

  assign w_issue     = !w_empty && is_legal(w_head_sel) &&
                       !unit_busy(w_head_sel, bus.int_busy_in, bus.vec_busy_in, bus.lsu_busy_in);
  assign w_drop_head = !w_empty && !is_legal(w_head_sel);
  assign w_pop       = (w_issue || w_drop_head) && !bus.flush_in;
  assign w_push_ok   = bus.push_valid_in && !w_full && !bus.flush_in;

  assign bus.push_ready_out = !w_full;
  assign bus.count_out      = r_count;
  assign bus.drop_count_out = r_drop_cnt;

`ifdef ISSUE_QUEUE_BYPASS_EN
  logic w_in_legal;
  logic w_bypass;

  assign w_in_legal = is_legal(bus.exec_unit_sel_in);
  assign w_bypass   = w_empty && bus.push_valid_in && w_in_legal &&
                      !unit_busy(bus.exec_unit_sel_in, bus.int_busy_in,
                                 bus.vec_busy_in, bus.lsu_busy_in);
  // An illegal offer into an empty queue is discarded at the door.
  assign w_drop_in  = w_empty && bus.push_valid_in && !w_in_legal;
  assign w_write    = w_push_ok && !w_bypass && !w_drop_in;

  assign bus.exec_unit_sel_out = w_bypass ? (bus.flush_in ? 3'b000 : bus.exec_unit_sel_in)
                                          : (w_issue ? w_head_sel : 3'b000);
  assign bus.exec_uop_out      = w_bypass ? (bus.flush_in ? 4'b0000 : bus.exec_uop_in)
                                          : (w_issue ? w_head_uop : 4'b0000);
`else
  assign w_drop_in = 1'b0;
  assign w_write   = w_push_ok;

  assign bus.exec_unit_sel_out = w_issue ? w_head_sel : 3'b000;
  assign bus.exec_uop_out      = w_issue ? w_head_uop : 4'b0000;
`endif

  assign w_drop_any = (w_drop_head || w_drop_in) && !bus.flush_in;

  always_ff @(posedge clock_in) begin
    if (w_write) begin
      r_sel_mem[r_wr_ptr] <= bus.exec_unit_sel_in;
      r_uop_mem[r_wr_ptr] <= bus.exec_uop_in;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (bus.flush_in) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_write) r_wr_ptr <= r_wr_ptr + c_ptr_one;
        if (w_pop)   r_rd_ptr <= r_rd_ptr + c_ptr_one;
        case ({w_write, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
      // Saturates so a long stream of garbage cannot wrap back to a small value.
      if (w_drop_any && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_issue_queue.sv
// ============================================================================
// Module   : tb_issue_queue
// Purpose  : Randomized + directed self-checking bench for issue_queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_issue_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0] sel;
    logic [3:0] uop;
  } ent_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  ent_t mq[$];
  int   mdrop;

  issue_queue_if #(.DEPTH(DEPTH)) bus ();

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clock_in (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_busy(input logic [2:0] s, input bit ib, input bit vb, input bit lb);
    case (s)
      3'b001:  return ib;
      3'b010:  return vb;
      3'b100:  return lb;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input bit v, input logic [2:0] s, input logic [3:0] u,
                       input bit ib, input bit vb, input bit lb, input bit fl);
    bus.push_valid_in    = v;
    bus.exec_unit_sel_in = s;
    bus.exec_uop_in      = u;
    bus.int_busy_in      = ib;
    bus.vec_busy_in      = vb;
    bus.lsu_busy_in      = lb;
    bus.flush_in         = fl;
  endtask

  // One cycle: drive, compare every output against the queue model, then
  // advance the model to the state the next rising edge must produce.
  task automatic step(input bit v, input logic [2:0] s, input logic [3:0] u,
                      input bit ib, input bit vb, input bit lb, input bit fl);
    logic [2:0] es;
    logic [3:0] eu;
    bit         pop;
    bit         drop;
    ent_t       e;
    @(negedge clk);
    drive(v, s, u, ib, vb, lb, fl);
    #1;
    es = 3'b000; eu = 4'b0000; pop = 1'b0; drop = 1'b0;
    if (mq.size() > 0) begin
      if (mq[0].sel inside {3'b001, 3'b010, 3'b100}) begin
        if (!model_busy(mq[0].sel, ib, vb, lb)) begin
          es = mq[0].sel; eu = mq[0].uop; pop = 1'b1;
        end
      end else begin
        pop = 1'b1; drop = 1'b1;
      end
    end
    vectors++;
    chk("sel",   int'(bus.exec_unit_sel_out), int'(es));
    chk("uop",   int'(bus.exec_uop_out),      int'(eu));
    chk("ready", int'(bus.push_ready_out),    int'(mq.size() < DEPTH));
    chk("count", int'(bus.count_out),         mq.size());
    chk("drop",  int'(bus.drop_count_out),    mdrop);
    if (fl) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (drop && mdrop < 255) mdrop++;
      if (v && mq.size() < DEPTH + (pop ? 1 : 0) && !(mq.size() + (pop ? 1 : 0) >= DEPTH)) begin
        e.sel = s; e.uop = u;
        mq.push_back(e);
      end
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("rst_count", int'(bus.count_out),         0);
    chk("rst_sel",   int'(bus.exec_unit_sel_out), 0);
    chk("rst_uop",   int'(bus.exec_uop_out),      0);
    chk("rst_ready", int'(bus.push_ready_out),    1);
    chk("rst_drop",  int'(bus.drop_count_out),    0);
    mq.delete();
    mdrop = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] sels [5];
    logic [2:0] rs;
    int         busy_pct;
    vectors = 0; miscompares = 0; mdrop = 0;
    rst = 1'b0;
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset();

    // Single INT entry, one cycle of latency.
    step(1, 3'b001, 4'h3, 0, 0, 0, 0);
    chk("lat_count0", int'(bus.count_out), 0);
    step(0, 3'b000, 4'h0, 0, 0, 0, 0);
    chk("lat_sel", int'(bus.exec_unit_sel_out), 1);
    chk("lat_uop", int'(bus.exec_uop_out), 3);
    chk("lat_count1", int'(bus.count_out), 1);
    step(0, 3'b000, 4'h0, 0, 0, 0, 0);
    chk("lat_count2", int'(bus.count_out), 0);

    // Busy INT head blocks a younger VEC entry.
    step(1, 3'b001, 4'h1, 1, 0, 0, 0);
    step(1, 3'b010, 4'h2, 1, 0, 0, 0);
    chk("block_sel0", int'(bus.exec_unit_sel_out), 0);
    step(0, 3'b000, 4'h0, 1, 0, 0, 0);
    chk("block_sel1", int'(bus.exec_unit_sel_out), 0);
    chk("block_count", int'(bus.count_out), 2);
    step(0, 3'b000, 4'h0, 0, 0, 0, 0);
    chk("rel_sel0", int'(bus.exec_unit_sel_out), 1);
    chk("rel_uop0", int'(bus.exec_uop_out), 1);
    step(0, 3'b000, 4'h0, 0, 0, 0, 0);
    chk("rel_sel1", int'(bus.exec_unit_sel_out), 2);
    chk("rel_uop1", int'(bus.exec_uop_out), 2);

    // Fill to full with all units busy, then drain across the pointer wrap.
    sels[0] = 3'b001; sels[1] = 3'b010; sels[2] = 3'b100; sels[3] = 3'b001; sels[4] = 3'b010;
    for (int i = 0; i < 5; i++) step(1, sels[i], 4'(i), 1, 1, 1, 0);
    chk("full_count", int'(bus.count_out), 4);
    chk("full_ready", int'(bus.push_ready_out), 0);
    for (int k = 0; k < 5; k++) begin
      step(k < 2, sels[4], 4'h4, 0, 0, 0, 0);
      chk("order_uop", int'(bus.exec_uop_out), k);
      if (k == 0) chk("full_ready_on_pop", int'(bus.push_ready_out), 0);
    end

    // Illegal head is dropped, the following LSU entry issues.
    step(1, 3'b011, 4'h5, 0, 0, 0, 0);
    step(1, 3'b100, 4'h7, 0, 0, 0, 0);
    chk("illegal_sel", int'(bus.exec_unit_sel_out), 0);
    step(0, 3'b000, 4'h0, 0, 0, 0, 0);
    chk("illegal_drop", int'(bus.drop_count_out), 1);
    chk("lsu_sel", int'(bus.exec_unit_sel_out), 4);
    chk("lsu_uop", int'(bus.exec_uop_out), 7);

    // Flush with three entries queued plus a same-cycle push.
    for (int i = 0; i < 3; i++) step(1, 3'b001, 4'(i + 1), 1, 1, 1, 0);
    step(1, 3'b001, 4'h9, 1, 1, 1, 1);
    chk("preflush_count", int'(bus.count_out), 3);
    step(0, 3'b000, 4'h0, 1, 1, 1, 0);
    chk("flush_count", int'(bus.count_out), 0);
    chk("flush_sel", int'(bus.exec_unit_sel_out), 0);
    step(0, 3'b000, 4'h0, 0, 0, 0, 0);
    chk("flush_lost", int'(bus.count_out), 0);

    // Asynchronous reset with two entries queued.
    step(1, 3'b001, 4'hA, 1, 1, 1, 0);
    step(1, 3'b010, 4'hB, 1, 1, 1, 0);
    @(negedge clk);
    drive(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("prerst_count", int'(bus.count_out), 2);
    chk("prerst_sel", int'(bus.exec_unit_sel_out), 1);
    async_reset();

    // Long run of illegal entries drives the drop counter into saturation.
    for (int i = 0; i < 262; i++) step(i < 260, 3'b000, 4'h0, 0, 0, 0, 0);
    chk("drop_sat", int'(bus.drop_count_out), 255);
    async_reset();

    busy_pct = 30;
    for (int c = 0; c < 1500; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       busy_pct = 10;
          1:       busy_pct = 50;
          default: busy_pct = 90;
        endcase
      end
      if (c % 500 == 499) async_reset();
      if ($urandom_range(0, 9) < 8) rs = 3'(1 << $urandom_range(0, 2));
      else                          rs = 3'($urandom_range(0, 7));
      step($urandom_range(0, 99) < 60, rs, 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < busy_pct, $urandom_range(0, 99) < busy_pct,
           $urandom_range(0, 99) < busy_pct, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
